pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline register for the in-order core. It is the generalised replacement for the fixed 32-bit stage registers (IF/ID, ID/EX, and so on). It carries an arbitrary-width payload under a valid/ready handshake with flush and bubble insertion. It optionally includes a skid entry that breaks the combinational ready path, and it counts back-pressure cycles for performance analysis.

---
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register with flush, bubble output
// and a saturating back-pressure counter.
// Build option: define PIPE_STAGE_SKID_EN to add the skid entry S, which
// registers ready_o and removes the ready_i -> ready_o combinational path.
module pipe_stage_reg #(
   parameter int unsigned            DATA_W = 64,
   parameter logic [DATA_W-1:0]      BUBBLE = {DATA_W{1'b0}},
   parameter int unsigned            CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] m_q;
   logic              load_m;
   logic              xfer_in, xfer_out;
   logic [CNT_W-1:0]  cnt_q;

   assign valid_o  = (state_q != ST_EMPTY);
   assign xfer_in  = valid_i & ready_o;
   assign xfer_out = valid_o & ready_i;
   assign data_o   = valid_o ? m_q : BUBBLE;

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] s_q;
   logic              load_s, m_from_s;

   // Ready depends on registered state only; reset holds it low.
   assign ready_o = !rst_i && (state_q != ST_SKID);

   // Next-state and register-load decode with the skid entry.
   always_comb begin
      state_d  = state_q;
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
      unique case (state_q)
         ST_EMPTY: if (xfer_in) begin
            load_m  = 1'b1;
            state_d = ST_FULL;
         end
         ST_FULL: begin
            if (xfer_in && xfer_out) begin
               load_m = 1'b1;
            end else if (xfer_in) begin
               load_s  = 1'b1;
               state_d = ST_SKID;
            end else if (xfer_out) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: if (xfer_out) begin
            m_from_s = 1'b1;
            state_d  = ST_FULL;
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush empties the stage; an incoming beat is swallowed.
      if (flush_i) begin
         state_d  = ST_EMPTY;
         load_m   = 1'b0;
         load_s   = 1'b0;
         m_from_s = 1'b0;
      end
   end

   // Payload registers carry no reset; state decides whether they matter.
   always_ff @(posedge clk_i) begin
      if (load_m)        m_q <= data_i;
      else if (m_from_s) m_q <= s_q;
      if (load_s)        s_q <= data_i;
   end
`else
   // Without the skid entry a full stage accepts only when it drains.
   assign ready_o = !rst_i && (!valid_o || ready_i);

   // Next-state and load decode for the two-state variant.
   always_comb begin
      state_d = state_q;
      load_m  = 1'b0;
      unique case (state_q)
         ST_EMPTY: if (xfer_in) begin
            load_m  = 1'b1;
            state_d = ST_FULL;
         end
         ST_FULL: begin
            if (xfer_in) begin
               load_m = 1'b1;
            end else if (xfer_out) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush empties the stage; an incoming beat is swallowed.
      if (flush_i) begin
         state_d = ST_EMPTY;
         load_m  = 1'b0;
      end
   end

   // Payload register carries no reset; state decides whether it matters.
   always_ff @(posedge clk_i) begin
      if (load_m) m_q <= data_i;
   end
`endif

   // State register; reset wins over flush (flush is folded into state_d).
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_EMPTY;
      else       state_q <= state_d;
   end

   // Saturating back-pressure counter, cleared by reset only.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else if (valid_o && !ready_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a queue scoreboard for
// pipe_stage_reg (8-bit payload, 4-bit counter, non-zero bubble).
module tb_pipe_stage_reg;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;
   localparam logic [DW-1:0] BUB = 8'hEE;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i, flush_i, valid_i, ready_i;
   logic          ready_o, valid_o;
   logic [DW-1:0] data_i, data_o;
   logic [CW-1:0] stall_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] src[$];   // upstream beats waiting to be accepted
   logic [DW-1:0] sb[$];    // expected output beats, in order
   int            cnt_m;    // expected stall count

   pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_ready();
      if (rst_i) return 1'b0;
      if (SKID)  return sb.size() < 2;
      return (sb.size() == 0) || ready_i;
   endfunction

   task automatic drive();
      valid_i = (src.size() != 0);
      data_i  = (src.size() != 0) ? src[0] : 8'h00;
   endtask

   // One clock: drive, check outputs against the model, advance the model.
   task automatic cycle();
      logic acc, outx;
      drive();
      @(negedge clk_i);
      chk("valid_o", {31'd0, valid_o}, {31'd0, sb.size() != 0});
      chk("ready_o", {31'd0, ready_o}, {31'd0, exp_ready()});
      chk("stall_cnt", {28'd0, stall_cnt_o}, cnt_m);
      if (sb.size() == 0) chk("bubble", {24'd0, data_o}, {24'd0, BUB});
      acc  = valid_i && exp_ready();
      outx = (sb.size() != 0) && ready_i;
      if (outx) chk("out_data", {24'd0, data_o}, {24'd0, sb[0]});
      if (rst_i) begin
         sb.delete();
         cnt_m = 0;
      end else begin
         if ((sb.size() != 0) && !ready_i && cnt_m < 15) cnt_m++;
         if (flush_i) sb.delete();
         else begin
            if (outx) void'(sb.pop_front());
            if (acc)  sb.push_back(data_i);
         end
      end
      @(posedge clk_i);
      #1;
      if (acc) void'(src.pop_front());
   endtask

   initial begin
      cnt_m = 0;
      rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
      valid_i = 1'b1; data_i = 8'hAA;
      @(posedge clk_i);
      #1;
      // Reset held two cycles with a valid 0xAA offered upstream.
      src.push_back(8'hAA);
      cycle();
      cycle();
      src.delete();
      rst_i = 1'b0;
      drive();
      #1;
      chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
      cycle();

      // Streaming 1,2,3 at full rate.
      src.push_back(8'h01); src.push_back(8'h02); src.push_back(8'h03);
      cycle();
      chk("stream_first", {24'd0, data_o}, 32'h01);
      cycle();
      chk("stream_second", {24'd0, data_o}, 32'h02);
      for (int i = 0; i < 3; i++) cycle();

      // Back-pressure: ready_i low for 3 cycles from when 0x10 appears.
      src.push_back(8'h10); src.push_back(8'h11); src.push_back(8'h12);
      cycle();
      ready_i = 1'b0;
      cycle();
      chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
      cycle();
      cycle();
      ready_i = 1'b1;
      chk("bp_stall_cnt", {28'd0, stall_cnt_o}, 32'd3);
      for (int i = 0; i < 5; i++) cycle();

      // Flush while holding 0x20/0x21 with 0x22 offered.
      ready_i = 1'b0;
      src.push_back(8'h20); src.push_back(8'h21);
      cycle();
      cycle();
      src.delete();
      src.push_back(8'h22);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      src.delete();
      drive();
      #1;
      chk("flush_valid", {31'd0, valid_o}, 32'd0);
      chk("flush_data", {24'd0, data_o}, {24'd0, BUB});
      chk("flush_ready", {31'd0, ready_o}, 32'd1);
      chk("flush_cnt_kept", {28'd0, stall_cnt_o}, 32'd5);
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Counter saturation.
      ready_i = 1'b0;
      src.push_back(8'h30);
      for (int i = 0; i < 21; i++) cycle();
      chk("cnt_saturated", {28'd0, stall_cnt_o}, 32'hF);
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Ready path: full stage, downstream stalled, then released.
      ready_i = 1'b0;
      src.push_back(8'h40);
      cycle();
      src.push_back(8'h41);
      drive();
      #1;
      chk("full_stall_ready", {31'd0, ready_o}, {31'd0, SKID});
      ready_i = 1'b1;
      #1;
      chk("release_ready", {31'd0, ready_o}, 32'd1);
      cycle();
      chk("replace_m", {24'd0, data_o}, 32'h41);
      chk("replace_valid", {31'd0, valid_o}, 32'd1);
      cycle();
      cycle();

      // Reset mid-operation discards held entries.
      ready_i = 1'b0;
      src.push_back(8'h50); src.push_back(8'h51);
      cycle();
      cycle();
      rst_i = 1'b1;
      cycle();
      src.delete();
      rst_i = 1'b0;
      chk("midrst_valid", {31'd0, valid_o}, 32'd0);
      chk("midrst_cnt", {28'd0, stall_cnt_o}, 32'd0);
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
